// File: rtl/text_stream_writer.sv
// text_stream_writer: turns a valid/ready ASCII stream into single-cell text-buffer writes with cursor control.
// Optional `define AUTO_CLEAR_ROW_EN blanks each row with spaces as the cursor moves onto it.
module text_stream_writer #(
    parameter int          COLS        = 60,
    parameter int          ROWS        = 20,
    parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_char,
    input  logic [11:0] in_color,
    input  logic        in_lang,
    input  logic        clear_req,
    output logic        write_enable,
    output logic [6:0]  write_x,
    output logic [4:0]  write_y,
    output logic [6:0]  write_data,
    output logic [11:0] write_text_color,
    output logic        write_lang,
    input  logic        busy,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y
);

    localparam logic [6:0] LAST_X = 7'(COLS - 1);
    localparam logic [4:0] LAST_Y = 5'(ROWS - 1);
    localparam logic [6:0] SPACE  = 7'h20;
    localparam logic [6:0] CH_BS  = 7'h08;
    localparam logic [6:0] CH_LF  = 7'h0A;
    localparam logic [6:0] CH_CR  = 7'h0D;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        CLEAR_ISSUE,
        CLEAR_GAP
    } state_t;

    state_t     state;
    logic       clear_pending;
    logic       row_only;
    logic [6:0] nxt_x;
    logic [4:0] nxt_y;
`ifdef AUTO_CLEAR_ROW_EN
    logic       nxt_row;
`endif

    logic [4:0] next_row;
    logic       at_eol;
    logic [6:0] adv_x;
    logic [4:0] adv_y;
    logic       printable;
    logic       full_clear;

    always_comb begin
        next_row   = (cursor_y == LAST_Y) ? '0 : cursor_y + 5'd1;
        at_eol     = (cursor_x == LAST_X);
        adv_x      = at_eol ? '0 : cursor_x + 7'd1;
        adv_y      = at_eol ? next_row : cursor_y;
        printable  = (in_char >= 7'h20) && (in_char <= 7'h7E);
        full_clear = ((state == CLEAR_ISSUE) || (state == CLEAR_GAP)) && !row_only;
        in_ready   = (state == IDLE) && !clear_pending && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            clear_pending    <= 1'b0;
            row_only         <= 1'b0;
            nxt_x            <= '0;
            nxt_y            <= '0;
`ifdef AUTO_CLEAR_ROW_EN
            nxt_row          <= 1'b0;
`endif
            cursor_x         <= '0;
            cursor_y         <= '0;
            write_enable     <= 1'b0;
            write_x          <= '0;
            write_y          <= '0;
            write_data       <= '0;
            write_text_color <= '0;
            write_lang       <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            // A request during a full clear is absorbed; during a row blank it stays pending.
            if (clear_req && !full_clear) begin
                clear_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (clear_pending) begin
                        clear_pending    <= 1'b0;
                        row_only         <= 1'b0;
                        write_x          <= '0;
                        write_y          <= '0;
                        write_data       <= SPACE;
                        write_text_color <= CLEAR_COLOR;
                        write_lang       <= 1'b0;
                        state            <= CLEAR_ISSUE;
                    end else if (in_valid) begin
                        if (printable || (in_char == CH_BS && cursor_x != '0)) begin
                            write_y          <= cursor_y;
                            write_text_color <= in_color;
                            write_lang       <= in_lang;
                            nxt_y            <= printable ? adv_y : cursor_y;
`ifdef AUTO_CLEAR_ROW_EN
                            nxt_row          <= printable && at_eol;
`endif
                            if (printable) begin
                                write_x    <= cursor_x;
                                write_data <= in_char;
                                nxt_x      <= adv_x;
                            end else begin
                                write_x    <= cursor_x - 7'd1;
                                write_data <= SPACE;
                                nxt_x      <= cursor_x - 7'd1;
                            end
                            // Busy already sampled low at acceptance: strobe without a detour through ISSUE.
                            if (busy) begin
                                state <= ISSUE;
                            end else begin
                                write_enable <= 1'b1;
                                state        <= GAP;
                            end
                        end else if (in_char == CH_LF) begin
                            cursor_x <= '0;
                            cursor_y <= next_row;
`ifdef AUTO_CLEAR_ROW_EN
                            row_only         <= 1'b1;
                            write_x          <= '0;
                            write_y          <= next_row;
                            write_data       <= SPACE;
                            write_text_color <= CLEAR_COLOR;
                            write_lang       <= 1'b0;
                            state            <= CLEAR_ISSUE;
`endif
                        end else if (in_char == CH_CR) begin
                            cursor_x <= '0;
                        end
                    end
                end

                ISSUE: begin
                    if (!busy) begin
                        write_enable <= 1'b1;
                        state        <= GAP;
                    end
                end

                GAP: begin
                    cursor_x <= nxt_x;
                    cursor_y <= nxt_y;
`ifdef AUTO_CLEAR_ROW_EN
                    if (nxt_row) begin
                        row_only         <= 1'b1;
                        write_x          <= '0;
                        write_y          <= nxt_y;
                        write_data       <= SPACE;
                        write_text_color <= CLEAR_COLOR;
                        write_lang       <= 1'b0;
                        state            <= CLEAR_ISSUE;
                    end else
`endif
                    state <= IDLE;
                end

                CLEAR_ISSUE: begin
                    if (!busy) begin
                        write_enable <= 1'b1;
                        state        <= CLEAR_GAP;
                    end
                end

                CLEAR_GAP: begin
                    if (write_x == LAST_X && (row_only || write_y == LAST_Y)) begin
                        if (!row_only) begin
                            cursor_x <= '0;
                            cursor_y <= '0;
                        end
                        row_only <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        if (write_x == LAST_X) begin
                            write_x <= '0;
                            write_y <= write_y + 5'd1;
                        end else begin
                            write_x <= write_x + 7'd1;
                        end
                        state <= CLEAR_ISSUE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_stream_writer.sv
// Scoreboard bench for text_stream_writer: a cell/cursor reference model queues expected writes, a monitor pops them.
module tb_text_stream_writer;
    localparam int          COLS = 60;
    localparam int          ROWS = 20;
    localparam logic [11:0] CLR  = 12'h000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_char;
    logic [11:0] in_color;
    logic        in_lang;
    logic        clear_req;
    logic        write_enable;
    logic [6:0]  write_x;
    logic [4:0]  write_y;
    logic [6:0]  write_data;
    logic [11:0] write_text_color;
    logic        write_lang;
    logic        busy;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    logic busy_mode = 1'b0;
    logic busy_dir  = 1'b0;
    logic busy_rnd  = 1'b0;

    always #5 clk = ~clk;
    assign busy = busy_mode ? busy_rnd : busy_dir;
    always @(negedge clk) busy_rnd <= ($urandom_range(0, 2) == 0);

    text_stream_writer #(.COLS(COLS), .ROWS(ROWS), .CLEAR_COLOR(CLR)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .in_color(in_color), .in_lang(in_lang), .clear_req(clear_req),
        .write_enable(write_enable), .write_x(write_x), .write_y(write_y),
        .write_data(write_data), .write_text_color(write_text_color), .write_lang(write_lang),
        .busy(busy), .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    typedef struct { int x; int y; int d; int c; int l; } wr_t;
    wr_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  strobes  = 0;
    int  mx = 0;
    int  my = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push_w(input int x, input int y, input int d, input int c, input int l);
        wr_t w;
        w.x = x; w.y = y; w.d = d; w.c = c; w.l = l;
        exp_q.push_back(w);
    endfunction

    function automatic void newline();
        mx = 0;
        my = (my + 1) % ROWS;
`ifdef AUTO_CLEAR_ROW_EN
        for (int x = 0; x < COLS; x++) push_w(x, my, 32, int'(CLR), 0);
`endif
    endfunction

    function automatic void model_char(input int c, input int col, input int lang);
        if (c >= 32 && c <= 126) begin
            push_w(mx, my, c, col, lang);
            if (mx == COLS - 1) newline();
            else mx++;
        end else if (c == 8) begin
            if (mx > 0) begin
                mx--;
                push_w(mx, my, 32, col, lang);
            end
        end else if (c == 10) begin
            newline();
        end else if (c == 13) begin
            mx = 0;
        end
    endfunction

    function automatic void model_clear();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) push_w(x, y, 32, int'(CLR), 0);
        mx = 0;
        my = 0;
    endfunction

    // Monitor: every strobe must match the head of the expected queue.
    logic busy_q = 1'b0;
    logic we_q   = 1'b0;
    always @(posedge clk) busy_q <= busy;
    always @(negedge clk) begin
        wr_t e;
        if (!reset && write_enable) begin
            strobes++;
            check("strobe_busy_low", int'(busy_q), 0);
            check("no_back_to_back", int'(we_q), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got x=%0d y=%0d data=%0h expected none", write_x, write_y, write_data);
            end else begin
                e = exp_q.pop_front();
                check("write_x", int'(write_x), e.x);
                check("write_y", int'(write_y), e.y);
                check("write_data", int'(write_data), e.d);
                check("write_color", int'(write_text_color), e.c);
                check("write_lang", int'(write_lang), e.l);
            end
        end
        we_q = write_enable && !reset;
    end

    task automatic send(input int c, input int col, input int lang);
        bit done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = 7'(c);
        in_color = 12'(col);
        in_lang  = lang[0];
        for (int i = 0; i < 20000 && !done; i++) begin
            #1;
            if (in_ready) begin
                model_char(c, col, lang);
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept of char %0h", c);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        #1;
        while (!(in_ready && exp_q.size() == 0) && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d writes outstanding expected 0", tag, exp_q.size());
        end
    endtask

    task automatic check_cursor(input string tag, input int ex, input int ey);
        check({tag, "_cx"}, int'(cursor_x), ex);
        check({tag, "_cy"}, int'(cursor_y), ey);
    endtask

    initial begin
        int s0;
        reset = 1'b1; in_valid = 1'b0; in_char = '0; in_color = '0; in_lang = 1'b0; clear_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_we", int'(write_enable), 0);
        check("rst_wx", int'(write_x), 0);
        check("rst_wdata", int'(write_data), 0);
        check("rst_wcolor", int'(write_text_color), 0);
        check_cursor("rst", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", int'(in_ready), 1);

        // 'A' with busy low: strobe one cycle after accept.
        send(8'h41, 12'hF00, 0);
        check("latency_we", int'(write_enable), 1);
        wait_idle("a");
        check_cursor("a", 1, 0);

        // 'B' held off by busy for five cycles.
        busy_dir = 1'b1;
        send(8'h42, 12'h0F0, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("busy_hold_we", int'(write_enable), 0);
            check("busy_hold_ready", int'(in_ready), 0);
            check("busy_hold_wx", int'(write_x), 1);
            check("busy_hold_data", int'(write_data), 8'h42);
            @(negedge clk);
        end
        busy_dir = 1'b0;
        @(negedge clk);
        #1;
        check("busy_release_we", int'(write_enable), 1);
        wait_idle("b");
        check_cursor("b", 2, 0);

        // Walk to (59,19) then wrap with 'Z'.
        send(13, 0, 0);
        for (int i = 0; i < ROWS - 1; i++) send(10, 0, 0);
        for (int i = 0; i < COLS - 1; i++) send(8'h78, int'($urandom_range(0, 4095)), 0);
        wait_idle("walk");
        check_cursor("corner", COLS - 1, ROWS - 1);
        send(8'h5A, 12'h00F, 1);
        wait_idle("wrap");
        check_cursor("wrap", 0, 0);

        // Backspace / newline / backspace at column 0.
        for (int i = 0; i < 3; i++) send(10, 0, 0);
        for (int i = 0; i < 5; i++) send(8'h61 + i, 12'h123, 0);
        wait_idle("pre_bs");
        check_cursor("pre_bs", 5, 3);
        send(8, 12'h456, 1);
        wait_idle("bs");
        check_cursor("bs", 4, 3);
        send(10, 0, 0);
        wait_idle("lf");
        check_cursor("lf", 0, 4);
        send(8, 12'h456, 0);
        wait_idle("bs0");
        check_cursor("bs0", 0, 4);

        // Full clear with a character waiting and a second clear_req mid-clear.
        busy_mode = 1'b1;
        s0 = strobes;
        @(negedge clk);
        clear_req = 1'b1;
        model_clear();
        @(negedge clk);
        clear_req = 1'b0;
        fork
            send(8'h43, 12'hABC, 1);
            begin
                repeat (300) @(negedge clk);
                clear_req = 1'b1;
                @(negedge clk);
                clear_req = 1'b0;
            end
        join
        wait_idle("clear");
        check("clear_strobes", strobes - s0, COLS * ROWS + 1);
        check_cursor("clear", 1, 0);

        // Randomized character stream with random busy.
        for (int n = 0; n < 400; n++) begin
            int r, c;
            r = int'($urandom_range(0, 9));
            if (r <= 5) c = int'($urandom_range(32, 126));
            else if (r == 6) c = 8;
            else if (r == 7) c = 10;
            else if (r == 8) c = 13;
            else begin
                c = int'($urandom_range(0, 32));
                if (c == 32 || c == 8 || c == 10 || c == 13) c = 127;
            end
            send(c, int'($urandom_range(0, 4095)), int'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (n % 50 == 49) begin
                wait_idle("rand");
                check_cursor("rand", mx, my);
            end
        end
        wait_idle("rand_end");
        check_cursor("rand_end", mx, my);

        // Reset during a write strobe: write_enable drops without a clock edge.
        busy_mode = 1'b0;
        busy_dir  = 1'b0;
        send(13, 0, 0);
        send(8'h51, 12'h321, 0);
        send(8'h52, 12'h321, 0);
        check("pre_rst_we", int'(write_enable), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_we", int'(write_enable), 0);
        check("async_rst_ready", int'(in_ready), 0);
        check_cursor("async_rst", 0, 0);
        exp_q.delete();
        mx = 0; my = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst1_ready", int'(in_ready), 1);

        // Reset while held in ISSUE by busy.
        send(8'h51, 12'h321, 0);
        wait_idle("q");
        busy_dir = 1'b1;
        send(8'h53, 12'h777, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("issue_rst_we", int'(write_enable), 0);
        check("issue_rst_wx", int'(write_x), 0);
        check_cursor("issue_rst", 0, 0);
        exp_q.delete();
        mx = 0; my = 0;
        @(negedge clk);
        reset    = 1'b0;
        busy_dir = 1'b0;
        #1;
        check("rst2_ready", int'(in_ready), 1);
        send(8'h54, 12'h888, 0);
        wait_idle("final");
        check_cursor("final", 1, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
